// File: rtl/cpu_bus_mem_ctrl.sv
// CPU bus to byte-wide synchronous RAM bridge: splits a 1-4 byte request into
// sequential little-endian byte accesses and returns a held ready handshake.
module cpu_bus_mem_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_bus_clk,
  input  logic              i_bus_we,
  input  logic [31:0]       i_bus_addr,
  input  logic [31:0]       i_bus_data,
  input  logic [1:0]        i_bus_size,
  output logic [31:0]       o_bus_data,
  output logic              o_bus_data_ready,
  output logic              o_busy,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_wdata,
  input  logic [7:0]        i_mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    WAIT,
    CAPTURE,
    DONE
  } state_e;

  localparam logic [3:0] WaitLoad = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);
  localparam bit         HasWait  = (WAIT_STATES > 0);

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         data_q, data_d;
  logic [1:0]          last_q, last_d;
  logic [1:0]          k_q, k_d;
  logic [3:0]          wcnt_q, wcnt_d;
  logic [31:0]         bus_data_q, bus_data_d;
  logic                out_of_range;

  assign out_of_range = ((i_bus_addr >> ADDR_W) != 32'd0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      last_q     <= '0;
      k_q        <= '0;
      wcnt_q     <= '0;
      bus_data_q <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      last_q     <= last_d;
      k_q        <= k_d;
      wcnt_q     <= wcnt_d;
      bus_data_q <= bus_data_d;
    end
  end

  // Ready is derived from DONE, so a new request in IDLE always sees ready low.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    data_d     = data_q;
    last_d     = last_q;
    k_d        = k_q;
    wcnt_d     = wcnt_q;
    bus_data_d = bus_data_q;
    unique case (state_q)
      IDLE: begin
        if (i_bus_clk) begin
          we_d       = i_bus_we;
          addr_d     = i_bus_addr[ADDR_W-1:0];
          data_d     = i_bus_data;
          last_d     = i_bus_size;
          k_d        = 2'd0;
          bus_data_d = 32'd0;
          state_d    = out_of_range ? DONE : ACCESS;
        end
      end
      ACCESS: begin
        wcnt_d  = WaitLoad;
        state_d = HasWait ? WAIT : CAPTURE;
      end
      WAIT: begin
        if (wcnt_q == 4'd0) begin
          state_d = CAPTURE;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      CAPTURE: begin
        if (!we_q) begin
          bus_data_d[{k_q, 3'b000} +: 8] = i_mem_rdata;
        end
        if (k_q == last_q) begin
          state_d = DONE;
        end else begin
          k_d     = k_q + 2'd1;
          state_d = ACCESS;
        end
      end
      DONE: begin
        if (!i_bus_clk) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Address arithmetic is ADDR_W bits wide, so multi-byte accesses wrap at the top of RAM.
  assign o_mem_en         = (state_q == ACCESS);
  assign o_mem_we         = o_mem_en & we_q;
  assign o_mem_addr       = addr_q + ADDR_W'(k_q);
  assign o_mem_wdata      = data_q[{k_q, 3'b000} +: 8];
  assign o_bus_data       = bus_data_q;
  assign o_bus_data_ready = (state_q == DONE);
  assign o_busy           = (state_q != IDLE);

  a_strobe_single: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    o_mem_en |=> !o_mem_en);
  a_no_strobe_when_ready: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    o_bus_data_ready |-> !o_mem_en);

endmodule

// File: tb/tb_cpu_bus_mem_ctrl.sv
// Scoreboard bench: two controllers (0 and 3 wait states) each driving a
// behavioural byte RAM; expected data/latency are queued at request time.
module tb_cpu_bus_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rstN;
  logic [1:0]        reqClk;
  logic              busWe;
  logic [31:0]       busAddr, busData;
  logic [1:0]        busSize;
  logic [1:0][31:0]  rdData;
  logic [1:0]        rdy, busy, memEn, memWe;
  logic [1:0][15:0]  memAddr;
  logic [1:0][7:0]   memWdata, memRdata;

  logic [7:0]  ram [2][65536];
  logic        loadEn, loadSel;
  logic [15:0] loadAddr;
  logic [7:0]  loadData;
  int          strobes [2] = '{0, 0};
  int          consec [2] = '{0, 0};
  logic [1:0]  prevEn = 2'b00;
  logic [15:0] strobeLog [2][64];

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] data;
    int          lat;
  } exp_t;
  exp_t sb[$];

  cpu_bus_mem_ctrl #(.ADDR_W(16), .WAIT_STATES(0)) dut0 (
    .i_clk(clk), .i_rst_n(rstN), .i_bus_clk(reqClk[0]), .i_bus_we(busWe),
    .i_bus_addr(busAddr), .i_bus_data(busData), .i_bus_size(busSize),
    .o_bus_data(rdData[0]), .o_bus_data_ready(rdy[0]), .o_busy(busy[0]),
    .o_mem_en(memEn[0]), .o_mem_we(memWe[0]), .o_mem_addr(memAddr[0]),
    .o_mem_wdata(memWdata[0]), .i_mem_rdata(memRdata[0])
  );

  cpu_bus_mem_ctrl #(.ADDR_W(16), .WAIT_STATES(3)) dut1 (
    .i_clk(clk), .i_rst_n(rstN), .i_bus_clk(reqClk[1]), .i_bus_we(busWe),
    .i_bus_addr(busAddr), .i_bus_data(busData), .i_bus_size(busSize),
    .o_bus_data(rdData[1]), .o_bus_data_ready(rdy[1]), .o_busy(busy[1]),
    .o_mem_en(memEn[1]), .o_mem_we(memWe[1]), .o_mem_addr(memAddr[1]),
    .o_mem_wdata(memWdata[1]), .i_mem_rdata(memRdata[1])
  );

  // Byte RAM per controller: read data appears after the strobe edge and holds until the next strobe.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (memEn[g]) begin
        if (memWe[g]) ram[g][memAddr[g]] <= memWdata[g];
        memRdata[g] <= ram[g][memAddr[g]];
        strobeLog[g][strobes[g] % 64] <= memAddr[g];
        strobes[g] <= strobes[g] + 1;
        if (prevEn[g]) consec[g] <= consec[g] + 1;
      end
    end
    prevEn <= memEn;
    if (loadEn) ram[loadSel][loadAddr] <= loadData;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic loadByte(input int sel, input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    loadEn   = 1'b1;
    loadSel  = sel[0];
    loadAddr = a;
    loadData = d;
    @(negedge clk);
    loadEn = 1'b0;
  endtask

  task automatic checkQuiet(input int sel, input string tag);
    checkOutput({tag, "Data"}, rdData[sel], 32'd0);
    checkOutput({tag, "Ctl"}, {28'd0, rdy[sel], busy[sel], memEn[sel], memWe[sel]}, 32'd0);
    checkOutput({tag, "Mem"}, {8'd0, memAddr[sel], memWdata[sel]}, 32'd0);
  endtask

  task automatic applyStimulus(input int sel, input logic we, input logic [31:0] addr,
                               input logic [31:0] data, input logic [1:0] size,
                               input logic [31:0] expData, input int expLat,
                               input int expStrobes, input bit dropEarly);
    int   edges;
    bit   got;
    int   s0;
    exp_t e;
    s0 = strobes[sel];
    @(negedge clk);
    busWe       = we;
    busAddr     = addr;
    busData     = data;
    busSize     = size;
    reqClk[sel] = 1'b1;
    sb.push_back('{expData, expLat});
    edges = 0;
    got   = 1'b0;
    while (!got && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
      if (rdy[sel]) begin
        got = 1'b1;
      end else if (edges == 1) begin
        busAddr = $urandom;
        busData = $urandom;
        busWe   = ~busWe;
        busSize = 2'($urandom);
        if (dropEarly) reqClk[sel] = 1'b0;
      end
    end
    if (!got) begin
      checkOutput("readyTimeout", 32'd0, 32'd1);
      reqClk[sel] = 1'b0;
      void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    checkOutput("latency", edges, e.lat);
    checkOutput("busData", rdData[sel], e.data);
    if (dropEarly) begin
      @(posedge clk);
      #1;
      checkOutput("readyPulse", 32'(rdy[sel]), 32'd0);
    end else begin
      repeat (3) begin
        @(posedge clk);
        #1;
        checkOutput("readyHold", 32'(rdy[sel]), 32'd1);
        checkOutput("dataHold", rdData[sel], e.data);
      end
      reqClk[sel] = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("readyDrop", 32'(rdy[sel]), 32'd0);
    end
    @(posedge clk);
    #1;
    checkOutput("idleAfter", 32'(busy[sel]), 32'd0);
    checkOutput("strobeCount", strobes[sel] - s0, expStrobes);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s0;
    rstN = 1'b0; reqClk = 2'b00; busWe = 1'b0; busAddr = '0; busData = '0; busSize = '0;
    loadEn = 1'b0; loadSel = 1'b0; loadAddr = '0; loadData = '0;
    repeat (2) @(negedge clk);
    checkQuiet(0, "reset0");
    checkQuiet(1, "reset1");
    rstN = 1'b1;

    $display("[TB] reset during ACCESS of a 4-byte write");
    for (int i = 0; i < 4; i++) loadByte(0, 16'h0400 + 16'(i), 8'h5A);
    s0 = strobes[0];
    @(negedge clk);
    busWe = 1'b1; busAddr = 32'h0000_0400; busData = 32'hA1B2_C3D4; busSize = 2'd3;
    reqClk[0] = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midAccessEn", 32'(memEn[0]), 32'd1);
    rstN = 1'b0;
    #1;
    checkQuiet(0, "asyncReset");
    reqClk[0] = 1'b0;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("postResetBusy", 32'(busy[0]), 32'd0);
    checkOutput("postResetStrobes", strobes[0] - s0, 32'd0);
    for (int i = 0; i < 4; i++) checkOutput("postResetRam", 32'(ram[0][16'h0400 + 16'(i)]), 32'h5A);

    $display("[TB] read, write, wrap, out-of-range and early-drop transfers");
    for (int g = 0; g < 2; g++) begin
      loadByte(g, 16'h0100, 8'h11);
      loadByte(g, 16'h0101, 8'h22);
      loadByte(g, 16'h0102, 8'h33);
      loadByte(g, 16'h0103, 8'h44);
    end
    applyStimulus(0, 1'b0, 32'h0000_0100, 32'h0, 2'd3, 32'h4433_2211, 9, 4, 1'b0);

    loadByte(1, 16'h0201, 8'h77);
    applyStimulus(1, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 2'd0, 32'h0, 6, 1, 1'b0);
    checkOutput("ws3WriteByte", 32'(ram[1][16'h0200]), 32'hEF);
    checkOutput("ws3NeighbourByte", 32'(ram[1][16'h0201]), 32'h77);

    loadByte(0, 16'hFFFF, 8'hAB);
    loadByte(0, 16'h0000, 8'hCD);
    s0 = strobes[0];
    applyStimulus(0, 1'b0, 32'h0000_FFFF, 32'h0, 2'd1, 32'h0000_CDAB, 5, 2, 1'b0);
    checkOutput("wrapAddr0", 32'(strobeLog[0][s0 % 64]), 32'h0000_FFFF);
    checkOutput("wrapAddr1", 32'(strobeLog[0][(s0 + 1) % 64]), 32'h0000_0000);

    applyStimulus(0, 1'b0, 32'h0001_0000, 32'h0, 2'd3, 32'h0, 1, 0, 1'b0);

    loadByte(0, 16'h0302, 8'h66);
    applyStimulus(0, 1'b1, 32'h0000_0300, 32'h9988_1234, 2'd1, 32'h0, 5, 2, 1'b1);
    checkOutput("dropByte0", 32'(ram[0][16'h0300]), 32'h34);
    checkOutput("dropByte1", 32'(ram[0][16'h0301]), 32'h12);
    checkOutput("dropByte2", 32'(ram[0][16'h0302]), 32'h66);

    applyStimulus(1, 1'b0, 32'h0000_0100, 32'h0, 2'd2, 32'h0033_2211, 16, 3, 1'b0);

    applyStimulus(0, 1'b1, 32'h0000_0500, 32'hCAFE_F00D, 2'd3, 32'h0, 9, 4, 1'b0);
    applyStimulus(0, 1'b0, 32'h0000_0500, 32'h0, 2'd3, 32'hCAFE_F00D, 9, 4, 1'b0);

    checkOutput("consecutiveStrobes0", consec[0], 32'd0);
    checkOutput("consecutiveStrobes1", consec[1], 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_bus_mem_ctrl.md
Name: cpu_bus_mem_ctrl

Overview:
- Memory-side controller directly downstream of the CPU core's bus port.
- Accepts the CPU's level-held request (bus_clk / we / addr / data) and performs 1–4 sequential byte accesses to a byte-wide synchronous RAM, little-endian.
- On reads, assembles the 32-bit word.
- Returns a held ready handshake to the CPU.

Parameters:
- ADDR_W, 16, memory address width; RAM depth is 2^ADDR_W bytes.
- WAIT_STATES, 0, extra idle cycles inserted between byte strobe and byte capture (0..15).

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_bus_clk  in  1  CPU request level; high = transfer requested
- i_bus_we  in  1  1 = write, 0 = read; sampled with request
- i_bus_addr  in  32  byte address; sampled with request
- i_bus_data  in  32  write data; sampled with request
- i_bus_size  in  2  byte count minus one (0 = 1 byte … 3 = 4 bytes)
- o_bus_data  out  32  assembled read data, valid while o_bus_data_ready = 1
- o_bus_data_ready  out  1  transfer complete
- o_busy  out  1  state != IDLE
- o_mem_en  out  1  RAM byte strobe
- o_mem_we  out  1  RAM write enable, qualified by o_mem_en
- o_mem_addr  out  ADDR_W  RAM byte address
- o_mem_wdata  out  8  RAM write byte
- i_mem_rdata  in  8  RAM read byte; valid the cycle after o_mem_en

Behaviour:
- Reset (async, i_rst_n = 0): state IDLE; all outputs 0.
  - o_bus_data, o_bus_data_ready, o_busy, o_mem_en, o_mem_we, o_mem_addr and o_mem_wdata are cleared.
  - Byte counter and latched request fields are cleared.
  - Reset mid-transfer aborts immediately; no further RAM strobes occur.
- States: IDLE, ACCESS, WAIT, CAPTURE, DONE.
- IDLE:
  - If i_bus_clk = 1 and o_bus_data_ready = 0, latch we, addr, data and n = i_bus_size + 1.
  - Clear o_bus_data to 0 and set byte index k = 0.
  - If addr[31:ADDR_W] != 0 (out of range), go to DONE with o_bus_data = 0 and no RAM access.
  - Otherwise go to ACCESS.
- ACCESS (1 cycle):
  - o_mem_en = 1, o_mem_we = latched we.
  - o_mem_addr = (addr + k) mod 2^ADDR_W; wraps at top of RAM.
  - o_mem_wdata = data[8k+7:8k].
  - Next state is WAIT if WAIT_STATES > 0, else CAPTURE.
- WAIT (WAIT_STATES cycles): o_mem_en = 0; counter runs down, then CAPTURE.
- CAPTURE (1 cycle):
  - On a read, o_bus_data[8k+7:8k] <= i_mem_rdata.
  - If k = n−1, go to DONE; else k <= k+1 and go to ACCESS.
- Byte lanes ≥ n read as 0. Write lanes ≥ n are ignored.
- DONE:
  - o_bus_data_ready = 1 and o_bus_data is held stable.
  - When i_bus_clk = 0, go to IDLE and clear o_bus_data_ready next edge.
  - A new request cannot start until ready has dropped, so every transfer has exactly one ready pulse.
- Latency: ready rises 1 + n·(WAIT_STATES+2) clock edges after the edge that sampled the request. Out-of-range requests take 1 edge.
- Request dropped mid-transfer: the transfer still completes and ready asserts for exactly one cycle.
- Inputs other than i_bus_clk are ignored outside IDLE.
- o_mem_en is never high in two consecutive cycles, and never high outside ACCESS.

Test Plan:
- Reset during ACCESS of a 4-byte write:
  - Assert i_rst_n = 0 → all outputs 0 asynchronously.
  - After release, remaining bytes are never written; state is IDLE.
- 4-byte read, WS = 0:
  - Setup: RAM[0x0100..0x0103] = 11 22 33 44, addr = 0x0100.
  - Response: o_bus_data = 0x44332211; ready rises 9 edges after sampling.
  - Ready stays high until i_bus_clk = 0, then falls next edge.
- 1-byte write, WS = 3:
  - Request: addr = 0x0200, data = 0xDEADBEEF, size = 0.
  - Response: single strobe, RAM[0x0200] = 0xEF, RAM[0x0201] unchanged; ready after 6 edges.
- Wrap with ADDR_W = 16:
  - Request: 2-byte read at 0xFFFF, RAM[0xFFFF] = 0xAB, RAM[0x0000] = 0xCD.
  - Response: strobes at 0xFFFF then 0x0000; o_bus_data = 0x0000CDAB.
- Out-of-range read at 0x00010000 → no o_mem_en; o_bus_data = 0; ready after 1 edge.
- Back-to-back and early-drop handshake:
  - i_bus_clk held high after DONE → no second transfer until it drops.
  - Request dropped after first ACCESS → transfer completes; ready high for 1 cycle.
